// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package mips_fetch_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] PC_INC = 32'd4;
  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // One queued fetch: instruction word tagged with its PC (64 bits total).
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] pc;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
    return {addr[INST_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {inst, pc} entries with flush.
// Storage is not reset; only pointers and occupancy are.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       wdata,
  output fetch_entry_t       rdata,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is legal only when the head leaves the same cycle.
  assign do_push = push & (~full | pop) & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  // Write the incoming entry at the tail.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Track pointers and occupancy; flush empties the queue in one edge.
  always_ff @(posedge clk) begin
    if (!Rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues one-at-a-time requests to a
// variable-latency instruction memory, queues returned words with their PC
// and hands them to decode over valid/ready. Redirects flush queued and
// in-flight work.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module inst_fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              halt,
  input  logic              redirect,
  input  logic [INST_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [INST_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [INST_W-1:0] inst_pc,
  output logic [INST_W-1:0] inst_pc4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushed
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic [INST_W-1:0] fetch_pc;
  logic [INST_W-1:0] new_pc;
  logic              ack_acc;
  logic              pop;
  logic              push;
  logic              full;
  logic              empty;
  logic              room;
  logic              room_after_push;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after_pop;
  fetch_entry_t      head;
  fetch_entry_t      wentry;
  logic              unused_pc_lsbs;

  // Low address bits of a redirect target carry no information.
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign new_pc         = word_align(redirect_pc);

  // Acks only count while a request is actually being presented.
  assign ack_acc = imem_req & imem_ack;
  // Redirect wins over a same-cycle pop and drops data from the current ack.
  assign pop     = inst_valid & inst_ready & ~redirect;
  assign push    = ack_acc & (state == REQ) & ~redirect;

  assign count_after_pop = count - CNT_W'(pop);
  assign room            = ~(full & ~pop);
  assign room_after_push = (count_after_pop < CNT_W'(DEPTH - 1));

  assign wentry.inst = imem_rdata;
  assign wentry.pc   = imem_addr;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .Rst   (Rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign inst_valid = ~empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;
  assign inst_pc4   = head.pc + PC_INC;

  // Fetch FSM with registered request/address; one request outstanding at most.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= new_pc;
      unique case (state)
        IDLE: begin
          if (!halt) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= new_pc;
          end
        end
        REQ, DRAIN: begin
          if (ack_acc) begin
            if (!halt) begin
              state     <= REQ;
              imem_addr <= new_pc;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end else begin
            state <= DRAIN;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (!halt && room) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (ack_acc) begin
            fetch_pc <= fetch_pc + PC_INC;
            if (!halt && room_after_push) begin
              imem_addr <= fetch_pc + PC_INC;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (ack_acc) begin
            if (!halt && room) begin
              state     <= REQ;
              imem_addr <= fetch_pc;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic discard_ack;
  assign discard_ack = ack_acc & ((state == DRAIN) | ((state == REQ) & redirect));

  // Count delivered fetches and work thrown away by redirects.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      stat_fetched <= 32'd0;
      stat_flushed <= 32'd0;
    end else begin
      if (push) begin
        stat_fetched <= stat_fetched + 32'd1;
      end
      stat_flushed <= stat_flushed + (redirect ? 32'(count) : 32'd0) + {31'd0, discard_ack};
    end
  end
`endif

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Fetch stage directly upstream of instruction decode in the CPU.
- Owns the fetch PC and issues word requests to an instruction memory that has a variable-latency req/ack interface.
- Buffers returned instructions, tagged with their PC, in a small FIFO.
- Presents them to decode with a valid/ready handshake, and discards in-flight or queued work when a branch/jump redirect arrives.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 32'h00000000, fetch PC after reset

Ports:
- clk  input  1  clock, all state updates on rising edge
- Rst  input  1  synchronous active-low reset
- halt  input  1  1 = issue no new fetch requests (PCWre=0 equivalent)
- redirect  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored and forced 0
- imem_req  output  1  request to instruction memory
- imem_addr  output  32  word address of request
- imem_ack  input  1  memory returns imem_rdata for current request this cycle
- imem_rdata  input  32  instruction word
- inst_valid  output  1  FIFO head valid
- inst_ready  input  1  decode consumes head when valid&ready
- inst  output  32  head instruction
- inst_pc  output  32  PC of head instruction
- inst_pc4  output  32  inst_pc + 4 (mod 2^32)

Behaviour:
- Reset (Rst=0 at edge):
  - fetch_pc = RESET_PC, FIFO count = 0, state = IDLE.
  - imem_req = 0, imem_addr = RESET_PC, inst_valid = 0.
- States:
  - IDLE: no request outstanding.
  - REQ: imem_req=1, waiting for ack.
  - DRAIN: request outstanding whose data must be discarded.
- Room condition: count < DEPTH, counted after this cycle's pop.
- Request rules:
  - At most one request outstanding.
  - imem_req and imem_addr are registered, and are held stable until the cycle imem_ack=1.
  - imem_ack is sampled only while imem_req=1; ack with req=0 is ignored.
- IDLE→REQ: when !halt and room; imem_addr = fetch_pc.
- REQ with ack:
  - Push {imem_rdata, imem_addr} to the FIFO; fetch_pc += 4.
  - If !halt and room remains after the push, stay in REQ with imem_addr = new fetch_pc, giving back-to-back requests at 1 instruction/cycle with zero-wait memory.
  - Otherwise go to IDLE with imem_req=0.
- Latency: the instruction is visible on inst/inst_valid the cycle after its ack.
- halt asserted while in REQ: the outstanding request completes normally; no new request follows.
- FIFO behaviour:
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle are allowed, including when full: count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push is never attempted when full, guaranteed by the room check at issue.
- Redirect (highest priority):
  - FIFO is flushed the same edge; inst_valid = 0 the next cycle.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Any pop presented in the same cycle is ignored.
  - If in REQ without ack this cycle → DRAIN.
  - If ack arrives the same cycle → that data is discarded; go directly to REQ at the new PC (or IDLE if halt).
  - If IDLE → REQ at the new PC next cycle (unless halt).
- DRAIN:
  - imem_req stays 1 on the old address until ack; data is discarded.
  - Then REQ at fetch_pc (or IDLE if halt).
  - A redirect in DRAIN only updates fetch_pc.
- Reset mid-operation: returns to the reset state immediately. The memory must tolerate a dropped req.
- PC arithmetic is 32-bit and wraps: 32'hFFFFFFFC + 4 = 0.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined:
  - Adds output ports stat_fetched[31:0] (increments on every accepted ack whose data was pushed) and stat_flushed[31:0] (increments by the number of entries discarded per redirect, plus 1 for each discarded ack).
  - Both counters reset to 0 and wrap.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_fetch_pkg holds:
  - the fetch state enum {IDLE, REQ, DRAIN}
  - INST_W=32
  - the PC increment constant 4
  - the default RESET_PC.
- One sub-module, fetch_fifo: parameterised DEPTH×64-bit (inst+pc) synchronous FIFO with push, pop, flush, count, full and empty.

Test Plan:
- Reset then zero-wait memory (ack same cycle as req), inst_ready=1 → imem_addr 0,4,8,… on consecutive cycles; inst_pc follows one cycle later; inst_pc4 = inst_pc+4.
- inst_ready=0 with DEPTH=4 → exactly 4 acks accepted, then imem_req=0; raising inst_ready → fetch resumes at 0x10.
- Memory 3-cycle latency, redirect to 0x100 in the cycle after the req for 0x8 → 0x8 data discarded (DRAIN), FIFO empty, next request address 0x100, first inst_pc 0x100.
- Redirect to 0x203 in the same cycle as ack → ack data dropped, next imem_addr = 0x200 the following cycle.
- halt=1 in REQ → outstanding ack completes, no further req; halt=0 → req resumes at the next sequential PC; Rst=0 mid-request → imem_req=0, inst_valid=0, imem_addr=RESET_PC next cycle.
- With FETCH_STATS_EN: 5 fetches, 2 queued entries flushed by redirect → stat_fetched=5, stat_flushed=2.
